alu_rs_scheduler: RTL and testbench

//  Allocation and issue controller for the ALU reservation-station array.
//  - Tracks which RS entries are occupied and hands free entries to up to PIPE_WIDTH dispatch slots per cycle.
//  - Keeps an age matrix over all entries.
//  - Each cycle, selects the oldest operand-ready entries for the NUM_ALU ALUs.
//  - Sits between dispatch, the RS entry array and the ALU execute stage.

---
 rtl/alu_rs_scheduler_if.sv | 34 +++
 rtl/alu_rs_scheduler.sv | 177 +++++++++++++++++
 tb/tb_alu_rs_scheduler.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rs_scheduler_if.sv
// Dispatch/issue bundle between the ALU reservation-station scheduler and its neighbours.
// The slave modport is the scheduler side; the master modport is dispatch, the entry array and the ALUs.
interface alu_rs_scheduler_if #(
  parameter int RS_SIZE    = 8,
  parameter int PIPE_WIDTH = 3,
  parameter int NUM_ALU    = 2
);
  localparam int SW = $clog2(PIPE_WIDTH);
  localparam int IW = $clog2(RS_SIZE);
  localparam int CW = $clog2(RS_SIZE) + 1;

  logic                    flush;
  logic                    cache_stall;
  logic [PIPE_WIDTH-1:0]   disp_req;
  logic [PIPE_WIDTH-1:0]   rs_rdy;
  logic [RS_SIZE-1:0]      alloc_we;
  logic [RS_SIZE*SW-1:0]   alloc_slot;
  logic [RS_SIZE-1:0]      entry_ready;
  logic [NUM_ALU-1:0]      alu_rdy;
  logic [NUM_ALU-1:0]      issue_valid;
  logic [NUM_ALU*IW-1:0]   issue_idx;
  logic [RS_SIZE-1:0]      entry_issue;
  logic [CW-1:0]           free_cnt;

  modport slave (
    input  flush, cache_stall, disp_req, entry_ready, alu_rdy,
    output rs_rdy, alloc_we, alloc_slot, issue_valid, issue_idx, entry_issue, free_cnt
  );

  modport master (
    output flush, cache_stall, disp_req, entry_ready, alu_rdy,
    input  rs_rdy, alloc_we, alloc_slot, issue_valid, issue_idx, entry_issue, free_cnt
  );
endinterface

// File: rtl/alu_rs_scheduler.sv
// ALU RS allocation + oldest-first issue over an age matrix; all outputs combinational (zero latency).
// Backpressure: rs_rdy thermometer from free_cnt, alu_rdy gates issue, cache_stall freezes everything.
module alu_rs_scheduler #(
  parameter int RS_SIZE    = 8,
  parameter int PIPE_WIDTH = 3,
  parameter int NUM_ALU    = 2
) (
  input  logic             clk,
  input  logic             rst,
  alu_rs_scheduler_if.slave bus
);
  localparam int SW = $clog2(PIPE_WIDTH);
  localparam int IW = $clog2(RS_SIZE);
  localparam int CW = $clog2(RS_SIZE) + 1;

  logic [RS_SIZE-1:0]               valid;
  logic [RS_SIZE-1:0][RS_SIZE-1:0]  older;
  logic [CW-1:0]                    free_cnt_q;

  logic                             active;
  logic                             stall_only;
  logic [RS_SIZE-1:0]               alloc_we;
  logic [RS_SIZE*SW-1:0]            alloc_slot;
  logic [RS_SIZE-1:0]               cand;
  logic [RS_SIZE-1:0]               oldest_oh;
  logic [RS_SIZE-1:0]               second_oh;
  logic [NUM_ALU-1:0]               issue_valid;
  logic [NUM_ALU*IW-1:0]            issue_idx;
  logic [RS_SIZE-1:0]               issue_oh;
  logic [CW-1:0]                    alloc_cnt;
  logic [CW-1:0]                    issue_cnt;
  logic [RS_SIZE-1:0][RS_SIZE-1:0]  older_nxt;

  assign active     = rst && !bus.flush && !bus.cache_stall;
  assign stall_only = bus.cache_stall && !bus.flush;

  function automatic logic [RS_SIZE-1:0] pick_oldest(
    input logic [RS_SIZE-1:0]              mask,
    input logic [RS_SIZE-1:0][RS_SIZE-1:0] age
  );
    logic [RS_SIZE-1:0] res;
    logic               blocked;
    res = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < RS_SIZE; j++) blocked = blocked | (mask[j] & age[j][i]);
      res[i] = mask[i] & ~blocked;
    end
    return res;
  endfunction

  function automatic logic [IW-1:0] encode(input logic [RS_SIZE-1:0] oh);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < RS_SIZE; i++) if (oh[i]) idx = IW'(i);
    return idx;
  endfunction

  always_comb begin
    for (int k = 0; k < PIPE_WIDTH; k++)
      bus.rs_rdy[k] = (int'(free_cnt_q) >= k + 1) && !stall_only;
  end

  // m-th requesting slot takes the m-th lowest free entry, capped by free_cnt.
  always_comb begin
    int n_req;
    int n_grant;
    int rank;
    int m;
    alloc_we   = '0;
    alloc_slot = '0;
    n_req      = 0;
    rank       = 0;
    m          = 0;
    for (int k = 0; k < PIPE_WIDTH; k++) n_req = n_req + int'(bus.disp_req[k]);
    n_grant = (n_req < int'(free_cnt_q)) ? n_req : int'(free_cnt_q);
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!valid[i]) begin
        if (active && rank < n_grant) begin
          alloc_we[i] = 1'b1;
          m = 0;
          for (int k = 0; k < PIPE_WIDTH; k++) begin
            if (bus.disp_req[k]) begin
              if (m == rank) alloc_slot[i*SW +: SW] = SW'(k);
              m = m + 1;
            end
          end
        end
        rank = rank + 1;
      end
    end
  end

  assign cand      = valid & bus.entry_ready;
  assign oldest_oh = pick_oldest(cand, older);
  assign second_oh = pick_oldest(cand & ~oldest_oh, older);

  always_comb begin
    issue_valid = '0;
    issue_idx   = '0;
    issue_oh    = '0;
    if (active && |oldest_oh) begin
      case (bus.alu_rdy)
        2'b11: begin
          issue_valid[0]    = 1'b1;
          issue_idx[IW-1:0] = encode(oldest_oh);
          issue_oh          = oldest_oh;
          if (|second_oh) begin
            issue_valid[1]       = 1'b1;
            issue_idx[2*IW-1:IW] = encode(second_oh);
            issue_oh             = oldest_oh | second_oh;
          end
        end
        2'b01: begin
          issue_valid[0]    = 1'b1;
          issue_idx[IW-1:0] = encode(oldest_oh);
          issue_oh          = oldest_oh;
        end
        2'b10: begin
          issue_valid[1]       = 1'b1;
          issue_idx[2*IW-1:IW] = encode(oldest_oh);
          issue_oh             = oldest_oh;
        end
        default: ;
      endcase
    end
  end

  assign alloc_cnt = CW'($countones(alloc_we));
  assign issue_cnt = CW'($countones(issue_oh));

  // New entries are younger than all survivors; same-cycle allocations order by slot.
  always_comb begin
    older_nxt = older;
    for (int i = 0; i < RS_SIZE; i++) begin
      for (int j = 0; j < RS_SIZE; j++) begin
        if (issue_oh[i] || issue_oh[j])
          older_nxt[i][j] = 1'b0;
        else if (alloc_we[j])
          older_nxt[i][j] = valid[i] ||
                            (alloc_we[i] && (alloc_slot[i*SW +: SW] < alloc_slot[j*SW +: SW]));
        else if (alloc_we[i])
          older_nxt[i][j] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid      <= '0;
      older      <= '0;
      free_cnt_q <= CW'(RS_SIZE);
    end else if (bus.flush) begin
      valid      <= '0;
      older      <= '0;
      free_cnt_q <= CW'(RS_SIZE);
    end else if (!bus.cache_stall) begin
      valid      <= (valid & ~issue_oh) | alloc_we;
      older      <= older_nxt;
      free_cnt_q <= free_cnt_q + issue_cnt - alloc_cnt;
    end
  end

  assign bus.alloc_we    = alloc_we;
  assign bus.alloc_slot  = alloc_slot;
  assign bus.issue_valid = issue_valid;
  assign bus.issue_idx   = issue_idx;
  assign bus.entry_issue = issue_oh;
  assign bus.free_cnt    = free_cnt_q;

  a_free_cnt: assert property (@(posedge clk) disable iff (!rst)
    free_cnt_q == CW'($countones(~valid)));
  a_distinct: assert property (@(posedge clk) disable iff (!rst)
    (&issue_valid) |-> (issue_idx[IW-1:0] != issue_idx[2*IW-1:IW]));
  a_no_realloc: assert property (@(posedge clk) disable iff (!rst)
    (alloc_we & valid) == '0);
endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Bench for alu_rs_scheduler: directed scenarios plus random traffic against an age-ordered queue model.
module tb_alu_rs_scheduler;
  localparam int RS = 8;
  localparam int PW = 3;
  localparam int NA = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  alu_rs_scheduler_if #(.RS_SIZE(RS), .PIPE_WIDTH(PW), .NUM_ALU(NA)) bus ();
  alu_rs_scheduler #(.RS_SIZE(RS), .PIPE_WIDTH(PW), .NUM_ALU(NA)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: valid entries kept oldest-first.
  int age_q[$];
  int new_ent[$];
  logic [7:0]  e_alloc_we;
  logic [15:0] e_alloc_slot;
  logic [1:0]  e_iv;
  logic [5:0]  e_idx;
  logic [7:0]  e_ei;
  logic [2:0]  e_rdy;
  logic [3:0]  e_fc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_eval();
    bit inq[RS];
    int freel[$];
    int reqs[$];
    int rdyl[$];
    int ng;
    int fc;
    bit act;
    fc   = RS - age_q.size();
    e_fc = 4'(fc);
    act  = rst && !bus.flush && !bus.cache_stall;
    for (int k = 0; k < PW; k++) e_rdy[k] = (fc >= k + 1) && !(bus.cache_stall && !bus.flush);
    foreach (age_q[n]) inq[age_q[n]] = 1'b1;
    for (int i = 0; i < RS; i++) if (!inq[i]) freel.push_back(i);
    for (int k = 0; k < PW; k++) if (bus.disp_req[k]) reqs.push_back(k);
    ng = (reqs.size() < freel.size()) ? reqs.size() : freel.size();
    e_alloc_we   = '0;
    e_alloc_slot = '0;
    new_ent.delete();
    if (act) begin
      for (int m = 0; m < ng; m++) begin
        e_alloc_we[freel[m]]           = 1'b1;
        e_alloc_slot[freel[m]*2 +: 2]  = 2'(reqs[m]);
        new_ent.push_back(freel[m]);
      end
    end
    foreach (age_q[n]) if (bus.entry_ready[age_q[n]]) rdyl.push_back(age_q[n]);
    e_iv  = '0;
    e_idx = '0;
    e_ei  = '0;
    if (act && rdyl.size() > 0) begin
      if (bus.alu_rdy == 2'b11) begin
        e_iv[0] = 1'b1; e_idx[2:0] = 3'(rdyl[0]);
        if (rdyl.size() > 1) begin e_iv[1] = 1'b1; e_idx[5:3] = 3'(rdyl[1]); end
      end else if (bus.alu_rdy == 2'b01) begin
        e_iv[0] = 1'b1; e_idx[2:0] = 3'(rdyl[0]);
      end else if (bus.alu_rdy == 2'b10) begin
        e_iv[1] = 1'b1; e_idx[5:3] = 3'(rdyl[0]);
      end
    end
    for (int p = 0; p < NA; p++) if (e_iv[p]) e_ei[e_idx[p*3 +: 3]] = 1'b1;
  endtask

  task automatic model_commit();
    int nq[$];
    if (!rst || bus.flush) begin
      age_q.delete();
    end else if (!bus.cache_stall) begin
      foreach (age_q[n]) if (!e_ei[age_q[n]]) nq.push_back(age_q[n]);
      foreach (new_ent[n]) nq.push_back(new_ent[n]);
      age_q = nq;
    end
  endtask

  task automatic compare_all();
    logic [15:0] slot_mask;
    logic [5:0]  idx_mask;
    slot_mask = '0;
    for (int i = 0; i < RS; i++) if (e_alloc_we[i]) slot_mask[i*2 +: 2] = 2'b11;
    idx_mask = {{3{e_iv[1]}}, {3{e_iv[0]}}};
    check("rs_rdy", 32'(bus.rs_rdy), 32'(e_rdy));
    check("free_cnt", 32'(bus.free_cnt), 32'(e_fc));
    check("alloc_we", 32'(bus.alloc_we), 32'(e_alloc_we));
    check("alloc_slot", 32'(bus.alloc_slot & slot_mask), 32'(e_alloc_slot));
    check("issue_valid", 32'(bus.issue_valid), 32'(e_iv));
    check("issue_idx", 32'(bus.issue_idx & idx_mask), 32'(e_idx));
    check("entry_issue", 32'(bus.entry_issue), 32'(e_ei));
  endtask

  task automatic drive(input logic f, input logic s, input logic [2:0] req,
                       input logic [7:0] rdy, input logic [1:0] alu);
    @(negedge clk);
    bus.flush       = f;
    bus.cache_stall = s;
    bus.disp_req    = req;
    bus.entry_ready = rdy;
    bus.alu_rdy     = alu;
    #1;
    model_eval();
    compare_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
  endtask

  initial begin
    int fc;
    logic [2:0] req;
    logic [2:0] therm;
    bus.flush = 1'b0; bus.cache_stall = 1'b0; bus.disp_req = '0;
    bus.entry_ready = '0; bus.alu_rdy = '0;

    // Held in reset: requests must not allocate.
    drive(0, 0, 3'b111, 8'hFF, 2'b11);
    check("rst_rs_rdy", 32'(bus.rs_rdy), 32'h7);
    check("rst_free_cnt", 32'(bus.free_cnt), 32'd8);
    check("rst_alloc_we", 32'(bus.alloc_we), 32'h0);
    check("rst_issue_valid", 32'(bus.issue_valid), 32'h0);
    advance();
    #2 rst = 1'b1;

    // Three slots into entries 0/1/2.
    drive(0, 0, 3'b111, 8'h00, 2'b00);
    check("t1_alloc_we", 32'(bus.alloc_we), 32'h07);
    check("t1_alloc_slot", 32'(bus.alloc_slot[5:0]), 32'h24);
    advance();
    drive(0, 0, 3'b000, 8'h00, 2'b00);
    check("t1_free_cnt", 32'(bus.free_cnt), 32'd5);
    advance();

    // Oldest two issue, third waits.
    drive(1, 0, 3'b000, 8'h00, 2'b00); advance();
    for (int c = 0; c < 3; c++) begin drive(0, 0, 3'b001, 8'h00, 2'b00); advance(); end
    drive(0, 0, 3'b000, 8'h07, 2'b11);
    check("t2_issue_valid", 32'(bus.issue_valid), 32'h3);
    check("t2_issue_idx", 32'(bus.issue_idx), 32'h08);
    check("t2_entry_issue", 32'(bus.entry_issue), 32'h03);
    advance();
    drive(0, 0, 3'b000, 8'h07, 2'b11);
    check("t2_second_valid", 32'(bus.issue_valid), 32'h1);
    check("t2_second_idx", 32'(bus.issue_idx[2:0]), 32'd2);
    advance();

    // Reallocated entry 0 is youngest; only ALU1 ready.
    drive(1, 0, 3'b000, 8'h00, 2'b00); advance();
    for (int c = 0; c < 4; c++) begin drive(0, 0, 3'b001, 8'h00, 2'b00); advance(); end
    drive(0, 0, 3'b000, 8'h01, 2'b01);
    check("t3_issue0", 32'(bus.issue_idx[2:0]), 32'd0);
    advance();
    drive(0, 0, 3'b001, 8'h00, 2'b00);
    check("t3_realloc", 32'(bus.alloc_we), 32'h01);
    advance();
    drive(0, 0, 3'b000, 8'h09, 2'b10);
    check("t3_issue_valid", 32'(bus.issue_valid), 32'h2);
    check("t3_issue_idx1", 32'(bus.issue_idx[5:3]), 32'd3);
    advance();

    // Full RS: freed entry is not reused in its issue cycle.
    drive(1, 0, 3'b000, 8'h00, 2'b00); advance();
    drive(0, 0, 3'b111, 8'h00, 2'b00); advance();
    drive(0, 0, 3'b111, 8'h00, 2'b00); advance();
    drive(0, 0, 3'b011, 8'h00, 2'b00); advance();
    drive(0, 0, 3'b001, 8'h01, 2'b01);
    check("t4_free_cnt", 32'(bus.free_cnt), 32'd0);
    check("t4_rs_rdy", 32'(bus.rs_rdy), 32'h0);
    check("t4_no_grant", 32'(bus.alloc_we), 32'h0);
    check("t4_issue_valid", 32'(bus.issue_valid), 32'h1);
    advance();
    drive(0, 0, 3'b001, 8'h00, 2'b00);
    check("t4_rs_rdy_next", 32'(bus.rs_rdy), 32'h1);
    check("t4_refill", 32'(bus.alloc_we), 32'h01);
    advance();
    drive(0, 0, 3'b000, 8'hFF, 2'b11);
    check("t4_full_dual", 32'(bus.issue_idx), 32'h11);
    advance();
    drive(0, 1, 3'b111, 8'hFF, 2'b11);
    check("t4_free_cnt2", 32'(bus.free_cnt), 32'd2);
    check("t5_stall_rs_rdy", 32'(bus.rs_rdy), 32'h0);
    check("t5_stall_alloc", 32'(bus.alloc_we), 32'h0);
    check("t5_stall_issue", 32'(bus.issue_valid), 32'h0);
    advance();
    drive(1, 0, 3'b111, 8'hFF, 2'b11);
    check("t5_held", 32'(bus.free_cnt), 32'd2);
    check("t5_flush_issue", 32'(bus.issue_valid), 32'h0);
    advance();
    drive(0, 0, 3'b000, 8'h00, 2'b00);
    check("t5_flushed", 32'(bus.free_cnt), 32'd8);
    advance();

    // Asynchronous reset in mid-cycle with six valid entries.
    drive(0, 0, 3'b111, 8'h00, 2'b00); advance();
    drive(0, 0, 3'b111, 8'h00, 2'b00); advance();
    drive(0, 0, 3'b000, 8'hFF, 2'b11);
    check("t6_pre_issue", 32'(bus.issue_valid), 32'h3);
    #2 rst = 1'b0;
    #1;
    check("t6_rs_rdy", 32'(bus.rs_rdy), 32'h7);
    check("t6_issue_valid", 32'(bus.issue_valid), 32'h0);
    check("t6_free_cnt", 32'(bus.free_cnt), 32'd8);
    age_q.delete();
    model_eval();
    compare_all();
    advance();
    #2 rst = 1'b1;

    // Random traffic, mostly obeying rs_rdy.
    for (int c = 0; c < 3000; c++) begin
      fc    = RS - age_q.size();
      therm = (fc >= 3) ? 3'b111 : (fc == 2) ? 3'b011 : (fc == 1) ? 3'b001 : 3'b000;
      req   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) req = req & therm;
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0), req,
            8'($urandom), 2'($urandom_range(0, 3)));
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
